imem_port_arbiter: RTL and testbench

// Shares the single-port instruction memory between fetch-stage reads and host program-load writes.

---
 rtl/imem_port_arbiter.sv | 89 ++++++++
 tb/tb_imem_port_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares a single-port instruction memory between fetch reads and host program-load writes
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   f_req_*                     fetch read request (valid/addr in, ready out)
//   f_flush                     drops every read still in flight
//   f_rsp_*                     instruction return (valid/addr registered, data passed through from mem_rdata)
//   h_wr_*                      host write request (valid/addr/data in, ready out)
//   h_lock / h_locked           bulk-load request / granted once reads have drained
//   mem_*                       memory port, driven combinationally from the granted request
module imem_port_arbiter #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 64,
  parameter int RD_LAT      = 2,
  parameter int HOST_STARVE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req_valid,
  input  logic [ADDR_W-1:0] f_req_addr,
  output logic              f_req_ready,
  input  logic              f_flush,
  output logic              f_rsp_valid,
  output logic [DATA_W-1:0] f_rsp_data,
  output logic [ADDR_W-1:0] f_rsp_addr,
  input  logic              h_wr_valid,
  input  logic [ADDR_W-1:0] h_wr_addr,
  input  logic [DATA_W-1:0] h_wr_data,
  output logic              h_wr_ready,
  input  logic              h_lock,
  output logic              h_locked,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int SW = $clog2(HOST_STARVE + 1);
  localparam logic [SW-1:0] SMAX = SW'(HOST_STARVE);
  typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_t;
  state_t                       state_q, state_d;
  logic [RD_LAT-1:0]            v_q, v_d;
  logic [RD_LAT-1:0][ADDR_W-1:0] a_q, a_d;
  logic [SW-1:0]                starve_q, starve_d;
  logic                         f_v, h_v, f_gnt, h_gnt;
  // Fetch is held off whenever lock is requested, so DRAIN never gains new entries
  // and LOAD->RUN can accept a read in the cycle the lock drops.
  always_comb begin
    f_v      = !rst && !h_lock && !f_flush && f_req_valid;
    h_v      = !rst && h_wr_valid;
    h_gnt    = h_v && (!f_v || starve_q == SMAX);
    f_gnt    = f_v && !h_gnt;
    starve_d = (!h_wr_valid || h_gnt) ? '0 : (starve_q == SMAX ? SMAX : starve_q + 1'b1);
    v_d      = '0;
    a_d      = '0;
    v_d[0]   = f_gnt;
    a_d[0]   = f_gnt ? f_req_addr : '0;
    for (int i = 1; i < RD_LAT; i++) begin
      v_d[i] = v_q[i-1];
      a_d[i] = a_q[i-1];
    end
    if (f_flush) v_d = '0;
    state_d = !h_lock ? RUN :
              state_q == RUN ? DRAIN :
              (state_q == DRAIN && |v_d) ? DRAIN : LOAD;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      v_q      <= '0;
      a_q      <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      v_q      <= v_d;
      a_q      <= a_d;
      starve_q <= starve_d;
    end
  end
  assign f_req_ready = f_gnt;
  assign h_wr_ready  = h_gnt;
  assign mem_en      = f_gnt || h_gnt;
  assign mem_we      = h_gnt;
  assign mem_addr    = h_gnt ? h_wr_addr : f_gnt ? f_req_addr : '0;
  assign mem_wdata   = h_gnt ? h_wr_data : '0;
  assign h_locked    = !rst && state_q == LOAD;
  assign f_rsp_valid = !rst && !f_flush && v_q[RD_LAT-1];
  assign f_rsp_addr  = a_q[RD_LAT-1];
  assign f_rsp_data  = f_rsp_valid ? mem_rdata : '0;
endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: directed-vector bench for imem_port_arbiter with a read-first two-cycle memory model
module tb_imem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        f_req_valid, f_req_ready, f_flush, f_rsp_valid;
  logic [9:0]  f_req_addr, f_rsp_addr;
  logic [63:0] f_rsp_data;
  logic        h_wr_valid, h_wr_ready, h_lock, h_locked;
  logic [9:0]  h_wr_addr;
  logic [63:0] h_wr_data;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [63:0] mem_wdata, r1, r2;
  logic [63:0] mem [1024];
  int          nvec = 0;
  int          nerr = 0;
  always #5 clk = ~clk;
  imem_port_arbiter #(.ADDR_W(10), .DATA_W(64), .RD_LAT(2), .HOST_STARVE(4)) dut (
    .clk(clk), .rst(rst),
    .f_req_valid(f_req_valid), .f_req_addr(f_req_addr), .f_req_ready(f_req_ready), .f_flush(f_flush),
    .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data), .f_rsp_addr(f_rsp_addr),
    .h_wr_valid(h_wr_valid), .h_wr_addr(h_wr_addr), .h_wr_data(h_wr_data), .h_wr_ready(h_wr_ready),
    .h_lock(h_lock), .h_locked(h_locked),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(r2)
  );
  always @(posedge clk) begin
    if (rst) for (int i = 0; i < 1024; i++) mem[i] <= 64'hC0DE_0000_0000_0000 + 64'(i);
    else if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    r1 <= mem[mem_addr];
    r2 <= r1;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string t, input logic [63:0] g, input logic [63:0] e);
    nvec++;
    if (g !== e) begin
      nerr++;
      $error("FAIL %s: got %h, expected %h", t, g, e);
    end
  endtask
  initial begin
    rst = 1'b1; f_req_valid = 1'b1; f_req_addr = 10'h0; f_flush = 1'b0;
    h_wr_valid = 1'b1; h_wr_addr = 10'h0; h_wr_data = 64'h0; h_lock = 1'b0;
    step(); step();
    chk("rst_f_ready", f_req_ready, 1'b0);
    chk("rst_h_ready", h_wr_ready, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_rsp_valid", f_rsp_valid, 1'b0);
    chk("rst_rsp_addr", f_rsp_addr, 10'h0);
    chk("rst_locked", h_locked, 1'b0);
    rst = 1'b0; f_req_valid = 1'b1; h_wr_valid = 1'b0; f_req_addr = 10'd0;
    #1;
    chk("t1_ready0", f_req_ready, 1'b1);
    chk("t1_mem_en", mem_en, 1'b1);
    chk("t1_mem_we", mem_we, 1'b0);
    step(); f_req_addr = 10'd1; #1;
    chk("t1_no_rsp_c1", f_rsp_valid, 1'b0);
    chk("t1_mem_addr1", mem_addr, 10'd1);
    step(); f_req_addr = 10'd2; #1;
    chk("t1_rsp0_v", f_rsp_valid, 1'b1);
    chk("t1_rsp0_a", f_rsp_addr, 10'd0);
    chk("t1_rsp0_d", f_rsp_data, 64'hC0DE_0000_0000_0000);
    step(); f_req_valid = 1'b0; #1;
    chk("t1_rsp1_a", f_rsp_addr, 10'd1);
    chk("t1_rsp1_d", f_rsp_data, 64'hC0DE_0000_0000_0001);
    step();
    chk("t1_rsp2_v", f_rsp_valid, 1'b1);
    chk("t1_rsp2_a", f_rsp_addr, 10'd2);
    chk("t1_rsp2_d", f_rsp_data, 64'hC0DE_0000_0000_0002);
    step();
    chk("t1_idle", f_rsp_valid, 1'b0);
    f_req_valid = 1'b1; f_req_addr = 10'd3; h_wr_valid = 1'b1; h_wr_addr = 10'd20; h_wr_data = 64'h1234;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("t2_f_ready", f_req_ready, (k % 5 != 4));
      chk("t2_h_ready", h_wr_ready, (k % 5 == 4));
      chk("t2_mem_we", mem_we, (k % 5 == 4));
      step();
    end
    f_req_valid = 1'b0; h_wr_valid = 1'b0;
    step(); step(); step();
    f_req_valid = 1'b1; f_req_addr = 10'd4;
    step(); f_req_addr = 10'd5;
    step(); f_req_addr = 10'd6; f_flush = 1'b1; #1;
    chk("t3_flush_ready", f_req_ready, 1'b0);
    chk("t3_flush_rsp", f_rsp_valid, 1'b0);
    step(); f_flush = 1'b0; f_req_valid = 1'b0; #1;
    chk("t3_post_flush1", f_rsp_valid, 1'b0);
    step(); f_req_valid = 1'b1; f_req_addr = 10'd7; #1;
    chk("t3_post_flush2", f_rsp_valid, 1'b0);
    chk("t3_new_ready", f_req_ready, 1'b1);
    step(); f_req_valid = 1'b0;
    step();
    chk("t3_new_v", f_rsp_valid, 1'b1);
    chk("t3_new_a", f_rsp_addr, 10'd7);
    chk("t3_new_d", f_rsp_data, 64'hC0DE_0000_0000_0007);
    step();
    f_req_valid = 1'b1; f_req_addr = 10'd8;
    step(); f_req_addr = 10'd9;
    step(); f_req_valid = 1'b0; h_lock = 1'b1; #1;
    chk("t4_rsp8_a", f_rsp_addr, 10'd8);
    chk("t4_rsp8_v", f_rsp_valid, 1'b1);
    chk("t4_locked_c2", h_locked, 1'b0);
    step(); f_req_valid = 1'b1; f_req_addr = 10'h12; #1;
    chk("t4_rsp9_a", f_rsp_addr, 10'd9);
    chk("t4_rsp9_v", f_rsp_valid, 1'b1);
    chk("t4_drain_ready", f_req_ready, 1'b0);
    chk("t4_locked_c3", h_locked, 1'b0);
    step();
    chk("t4_locked", h_locked, 1'b1);
    chk("t4_no_rsp", f_rsp_valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      h_wr_valid = 1'b1; h_wr_addr = 10'h10 + 10'(k); h_wr_data = 64'hBEEF_0000_0000_0010 + 64'(k); #1;
      chk("t4_h_ready", h_wr_ready, 1'b1);
      chk("t4_f_blocked", f_req_ready, 1'b0);
      step();
    end
    h_wr_valid = 1'b0; h_lock = 1'b0; #1;
    chk("t4_unlock_ready", f_req_ready, 1'b1);
    step(); f_req_valid = 1'b0;
    step();
    chk("t4_new_v", f_rsp_valid, 1'b1);
    chk("t4_new_a", f_rsp_addr, 10'h12);
    chk("t4_new_d", f_rsp_data, 64'hBEEF_0000_0000_0012);
    chk("t4_unlocked", h_locked, 1'b0);
    step();
    f_req_valid = 1'b1; f_req_addr = 10'd5;
    step(); f_req_valid = 1'b0; h_wr_valid = 1'b1; h_wr_addr = 10'd5; h_wr_data = 64'hFACE_0000_0000_0005; #1;
    chk("t5_wr_ready", h_wr_ready, 1'b1);
    step(); h_wr_valid = 1'b0; #1;
    chk("t5_old_v", f_rsp_valid, 1'b1);
    chk("t5_old_d", f_rsp_data, 64'hC0DE_0000_0000_0005);
    step(); f_req_valid = 1'b1;
    step(); f_req_valid = 1'b0;
    step();
    chk("t5_new_a", f_rsp_addr, 10'd5);
    chk("t5_new_d", f_rsp_data, 64'hFACE_0000_0000_0005);
    step();
    f_req_valid = 1'b1; f_req_addr = 10'd1;
    step(); f_req_addr = 10'd2;
    step(); f_req_valid = 1'b0; rst = 1'b1; #1;
    chk("t6_rst_rsp", f_rsp_valid, 1'b0);
    step(); rst = 1'b0; #1;
    chk("t6_after_rst1", f_rsp_valid, 1'b0);
    step();
    chk("t6_after_rst2", f_rsp_valid, 1'b0);
    h_lock = 1'b1;
    step(); step();
    chk("t6_locked", h_locked, 1'b1);
    rst = 1'b1; h_lock = 1'b0; #1;
    chk("t6_rst_locked", h_locked, 1'b0);
    step(); rst = 1'b0; f_req_valid = 1'b1; f_req_addr = 10'd3; #1;
    chk("t6_run_locked", h_locked, 1'b0);
    chk("t6_run_ready", f_req_ready, 1'b1);
    step(); f_req_valid = 1'b0;
    step(); step();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
